prod_accum: RTL and testbench
=============================

Name: prod_accum

Overview:
- Downstream consumer of the 8x8 shift-add multiplier's 16-bit unsigned product.
- Accumulates a fixed-length frame of LEN products into a wide accumulator, then presents the frame sum on a registered valid/ready output.
- Upstream side uses a valid/ready handshake. The multiplier output is registered by the producer before reaching in_data.
- Typical use: dot-product / FIR tap summation after the multiplier array.

Parameters:
- IN_W, 16, product width; in_data is zero-extended (unsigned).
- ACC_W, 24, accumulator and out_data width; must be greater than or equal to IN_W.
- LEN, 8, products per frame; legal values are 1..255.
- SAT, 1, 1 = saturate on overflow to all-ones; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous frame abort, highest priority after reset.
- in_valid  in  1  product valid.
- in_ready  out  1  block accepts a product this cycle.
- in_data  in  IN_W  unsigned product.
- out_valid  out  1  frame sum valid.
- out_ready  in  1  downstream accepts the sum.
- out_data  out  ACC_W  frame sum.
- out_ovf  out  1  overflow occurred in this frame; qualified by out_valid.
- acc_cnt  out  8  products accepted so far in the current frame.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - state = ACC; acc = 0; acc_cnt = 0.
  - ovf_sticky = 0; out_valid = 0; out_data = 0; out_ovf = 0.
- Reset takes effect immediately and can occur at any point, including mid-frame or while holding a result. Partial frames are discarded.
- States:
  - ACC (collecting products).
  - DONE (holding result).
- Handshake signals:
  - in_ready = (state==ACC) && !clr, decoded combinationally from state.
  - A transfer is in_valid && in_ready on a rising edge.
  - An output transfer is out_valid && out_ready on a rising edge.
- ACC, on each input transfer:
  - sum = acc + zero-extended in_data, computed ACC_W+1 bits wide.
  - If sum[ACC_W] is set: ovf_sticky <= 1. With SAT=1, acc <= all-ones; with SAT=0, acc <= sum[ACC_W-1:0].
  - Otherwise acc <= sum[ACC_W-1:0].
  - acc_cnt increments by 1.
- Once saturated (SAT=1), acc stays all-ones for the rest of the frame.
- ACC, final transfer (acc_cnt == LEN-1):
  - out_data <= the post-update acc value; out_ovf <= post-update ovf.
  - out_valid <= 1; state <= DONE.
  - acc, acc_cnt and ovf_sticky clear to 0 on the same edge.
- Latency: out_valid rises on the edge that accepts the last product, so it is visible in the following cycle.
- DONE:
  - in_ready = 0.
  - out_data and out_ovf are held stable while out_valid=1 && !out_ready.
  - On an output transfer: out_valid <= 0 and state <= ACC, so in_ready is 1 in the next cycle.
- Throughput: LEN+1 cycles per frame at best (one bubble cycle for DONE).
- out_valid never deasserts without an output transfer, except by clr or reset.
- in_valid while in_ready=0: the product is not consumed and no state changes. The producer must hold in_data.
- clr=1: on the next edge, state <= ACC, acc <= 0, acc_cnt <= 0, ovf_sticky <= 0, out_valid <= 0.
  - Any pending result is dropped.
  - in_ready is 0 during the clr cycle, so no product is accepted.
  - clr simultaneous with a final input transfer or an output transfer: clr wins.
- LEN=1: every accepted product immediately produces a frame (DONE follows each transfer).
- Sums are unsigned; there is no rounding or truncation other than the overflow rules above.

Test Plan:
- Defaults, 8 transfers of 65025 (255*255) back-to-back, out_ready=1 → out_valid one cycle after the 8th edge; out_data=520200, out_ovf=0; in_ready=0 for exactly one cycle, then frame 2 is accepted.
- ACC_W=17, SAT=1, LEN=4, products 65025 x3 → out_data=131071 (saturated), out_ovf=1 after the 4th product (value 0); next frame 1,1,1,1 → out_data=4, out_ovf=0 (sticky cleared).
- ACC_W=17, SAT=0, LEN=3, products 65025 x3 → out_data=64003 (195075 mod 131072), out_ovf=1.
- Backpressure: frame of 1,2,...,8 completes (out_data=36); out_ready=0 for 5 cycles while in_valid=1 with data 99 → in_ready=0 throughout, out_data stable at 36, acc_cnt=0; after out_ready=1, the next edge accepts nothing, and the following cycle accepts 99 with acc_cnt→1.
- Two products 500,600 accepted, then clr for one cycle while in_valid=1 → acc_cnt=0, no transfer during clr; then LEN products 1,2,3,4,0,0,0,0 → out_data=10.
- Reset mid-frame (acc_cnt=5) and during DONE with out_valid=1 → all outputs read 0 while rst_n is low, out_valid=0 immediately; after release, a full 8-product frame sums correctly from 0.

Source files
------------

// File: rtl/prod_accum.sv
// ---------------------------------------------------------------------------
// prod_accum - sums LEN unsigned products per frame, valid/ready in and out.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module prod_accum #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int LEN   = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [7:0]       acc_cnt
);

  localparam int         c_pad  = ACC_W - IN_W + 1;
  localparam logic [7:0] c_last = 8'(LEN - 1);

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_data_q, out_data_d;
  logic               out_ovf_q, out_ovf_d;

  logic               w_xfer;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_upd;
  logic               w_ovf_upd;

  assign in_ready  = (state_q == ST_ACC) && !clr;
  assign w_xfer    = in_valid && in_ready;
  assign w_sum     = {1'b0, acc_q} + {{c_pad{1'b0}}, in_data};
  // Once saturated, adding anything keeps the carry set or leaves all-ones.
  assign w_acc_upd = (w_sum[ACC_W] && SAT) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_ovf_upd = ovf_q | w_sum[ACC_W];

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (clr) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (w_xfer) begin
            if (cnt_q == c_last) begin
              out_data_d  = w_acc_upd;
              out_ovf_d   = w_ovf_upd;
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
            end else begin
              acc_d = w_acc_upd;
              cnt_d = cnt_q + 8'd1;
              ovf_d = w_ovf_upd;
            end
          end
        end
        ST_DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_ACC;
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign acc_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prod_accum.sv
// ---------------------------------------------------------------------------
// tb_prod_accum - directed checks of prod_accum in three configurations.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_prod_accum;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  // Default configuration
  logic        m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_out_ovf;
  logic [15:0] m_in_data;
  logic [23:0] m_out_data;
  logic [7:0]  m_acc_cnt;

  // ACC_W=17, SAT=1, LEN=4
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_ovf;
  logic [15:0] s_in_data;
  logic [16:0] s_out_data;
  logic [7:0]  s_acc_cnt;

  // ACC_W=17, SAT=0, LEN=3
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_ovf;
  logic [15:0] w_in_data;
  logic [16:0] w_out_data;
  logic [7:0]  w_acc_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prod_accum u_main (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
    .out_ovf(m_out_ovf), .acc_cnt(m_acc_cnt)
  );

  prod_accum #(.IN_W(16), .ACC_W(17), .LEN(4), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_ovf(s_out_ovf), .acc_cnt(s_acc_cnt)
  );

  prod_accum #(.IN_W(16), .ACC_W(17), .LEN(3), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_ovf(w_out_ovf), .acc_cnt(w_acc_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0;
    m_in_valid = 1'b0; m_in_data = '0; m_out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;
    #12;
    checks++;
    if (m_out_valid !== 1'b0 || m_out_data !== 24'd0 || m_out_ovf !== 1'b0 || m_acc_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b d=%0d o=%b c=%0d, need 0 0 0 0", m_out_valid, m_out_data, m_out_ovf, m_acc_cnt);
    end
    checks++;
    if (m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b need 1", m_in_ready);
    end
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    m_in_valid = 1'b1; m_in_data = 16'd65025; m_out_ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (m_acc_cnt !== 8'(k) || m_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_count: got cnt=%0d v=%b need cnt=%0d v=0", m_acc_cnt, m_out_valid, k);
      end
    end
    tick();
    checks++;
    if (m_out_valid !== 1'b1 || m_out_data !== 24'd520200 || m_out_ovf !== 1'b0 ||
        m_in_ready !== 1'b0 || m_acc_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_frame1: got v=%b d=%0d o=%b rdy=%b c=%0d need 1 520200 0 0 0",
               m_out_valid, m_out_data, m_out_ovf, m_in_ready, m_acc_cnt);
    end
    tick();
    checks++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_acc_cnt !== 8'd0) begin
      errors++;
      $display("FAIL b2b_bubble: got v=%b rdy=%b c=%0d need 0 1 0", m_out_valid, m_in_ready, m_acc_cnt);
    end
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (m_out_valid !== 1'b1 || m_out_data !== 24'd520200 || m_out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL b2b_frame2: got v=%b d=%0d o=%b need 1 520200 0", m_out_valid, m_out_data, m_out_ovf);
    end
    m_in_valid = 1'b0;
    tick();
    m_out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    s_in_valid = 1'b1; s_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_in_data = (k < 3) ? 16'd65025 : 16'd0;
      tick();
    end
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 17'd131071 || s_out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sat_frame: got v=%b d=%0d o=%b need 1 131071 1", s_out_valid, s_out_data, s_out_ovf);
    end
    s_in_valid = 1'b0;
    tick();
    s_in_valid = 1'b1; s_in_data = 16'd1;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== 17'd4 || s_out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sat_sticky_clear: got v=%b d=%0d o=%b need 1 4 0", s_out_valid, s_out_data, s_out_ovf);
    end
    s_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    w_in_valid = 1'b1; w_in_data = 16'd65025; w_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (w_out_valid !== 1'b1 || w_out_data !== 17'd64003 || w_out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_frame: got v=%b d=%0d o=%b need 1 64003 1", w_out_valid, w_out_data, w_out_ovf);
    end
    w_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    m_in_valid = 1'b1; m_out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      m_in_data = 16'(k);
      tick();
    end
    checks++;
    if (m_out_valid !== 1'b1 || m_out_data !== 24'd36) begin
      errors++;
      $display("FAIL bp_frame: got v=%b d=%0d need 1 36", m_out_valid, m_out_data);
    end
    m_in_data = 16'd99;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1 || m_out_data !== 24'd36 || m_acc_cnt !== 8'd0) begin
        errors++;
        $display("FAIL bp_hold: got rdy=%b v=%b d=%0d c=%0d need 0 1 36 0",
                 m_in_ready, m_out_valid, m_out_data, m_acc_cnt);
      end
    end
    m_out_ready = 1'b1;
    tick();
    checks++;
    if (m_out_valid !== 1'b0 || m_acc_cnt !== 8'd0 || m_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b c=%0d rdy=%b need 0 0 1", m_out_valid, m_acc_cnt, m_in_ready);
    end
    tick();
    checks++;
    if (m_acc_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_accept: got cnt=%0d need 1", m_acc_cnt);
    end
    m_in_valid = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_clr();
    m_in_valid = 1'b1; m_out_ready = 1'b1;
    m_in_data = 16'd500; tick();
    m_in_data = 16'd600; tick();
    checks++;
    if (m_acc_cnt !== 8'd2) begin
      errors++;
      $display("FAIL clr_pre: got cnt=%0d need 2", m_acc_cnt);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (m_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_in_ready: got %b need 0", m_in_ready);
    end
    tick();
    clr = 1'b0;
    checks++;
    if (m_acc_cnt !== 8'd0 || m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_abort: got cnt=%0d v=%b need 0 0", m_acc_cnt, m_out_valid);
    end
    for (int k = 1; k <= 8; k++) begin
      m_in_data = (k <= 4) ? 16'(k) : 16'd0;
      tick();
    end
    checks++;
    if (m_out_valid !== 1'b1 || m_out_data !== 24'd10 || m_out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clr_next_frame: got v=%b d=%0d o=%b need 1 10 0", m_out_valid, m_out_data, m_out_ovf);
    end
    m_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_async();
    m_in_valid = 1'b1; m_in_data = 16'd7; m_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (m_acc_cnt !== 8'd5) begin
      errors++;
      $display("FAIL rst_mid_pre: got cnt=%0d need 5", m_acc_cnt);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (m_acc_cnt !== 8'd0 || m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: got cnt=%0d v=%b need 0 0", m_acc_cnt, m_out_valid);
    end
    #1 rst_n = 1'b1;
    m_in_data = 16'd1000;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (m_out_valid !== 1'b1 || m_out_data !== 24'd8000) begin
      errors++;
      $display("FAIL rst_done_pre: got v=%b d=%0d need 1 8000", m_out_valid, m_out_data);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (m_out_valid !== 1'b0 || m_out_data !== 24'd0 || m_out_ovf !== 1'b0 || m_acc_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_done: got v=%b d=%0d o=%b c=%0d need 0 0 0 0", m_out_valid, m_out_data, m_out_ovf, m_acc_cnt);
    end
    #1 rst_n = 1'b1;
    m_out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      m_in_data = 16'(k);
      tick();
    end
    checks++;
    if (m_out_valid !== 1'b1 || m_out_data !== 24'd36 || m_out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_after: got v=%b d=%0d o=%b need 1 36 0", m_out_valid, m_out_data, m_out_ovf);
    end
    m_in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_saturate();
    test_wrap();
    test_backpressure();
    test_clr();
    test_reset_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
